iommu_reg_access_ctrl: RTL and testbench
========================================

# iommu_reg_access_ctrl

Access controller for a bank of IOMMU register fields. It accepts one software register access at a time from a simple request/grant bus and turns it into single-cycle write or read strobes for the addressed field. It also arbitrates update requests from several hardware requesters onto the fields' hardware-update inputs, using round-robin order. It sits between the bus adapter and the field instances and sequences both access paths.

## Interface
- NF, default 8: number of fields; field k sits at word address k.
- DW, default 32: field width; must be 32.
- NH, default 3: number of hardware update requesters.
- AW, default 8: word-address width.
- IW, default $clog2(NF): width of the field index.
- clk_i, input, 1: clock.
- rst_ni, input, 1: reset, asynchronous, active-low.
- req_i, input, 1: software access request.
- gnt_o, output, 1: request accepted (combinational).
- we_i, input, 1: 1 = write, 0 = read.
- addr_i, input, AW: word address.
- wdata_i, input, DW: write data.
- be_i, input, DW/8: byte enables.
- rvalid_o, output, 1: response valid, one-cycle pulse.
- rdata_o, output, DW: read data.
- err_o, output, 1: error, qualified by rvalid_o.
- sw_we_o, output, NF: one-hot software write strobe.
- sw_re_o, output, NF: one-hot read pulse, used by read-to-clear fields.
- sw_wd_o, output, DW: merged software write data.
- field_qs_i, input, NF*DW: current field values; field k occupies [k*DW +: DW].
- hw_req_i, input, NH: hardware update requests.
- hw_idx_i, input, NH*IW: target field index per requester.
- hw_data_i, input, NH*DW: update data per requester.
- hw_gnt_o, output, NH: one-hot grant (combinational).
- field_de_o, output, NF: one-hot hardware update enable.
- field_d_o, output, DW: hardware update data.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - gnt_o = req_i.
  - On accept, register we_i, addr_i, wdata_i and be_i, then go to ACCESS.
- ACCESS (exactly 1 cycle):
  - If addr ≥ NF: no strobes; err is set.
  - Write: sw_we_o[addr] = 1. sw_wd_o = (qs & ~mask) | (wdata & mask), where mask expands each byte enable to 8 bits. be = 0 still pulses sw_we_o, with sw_wd_o equal to the current qs.
  - Read: sw_re_o[addr] = 1. rdata is captured from field_qs_i[addr], which is the pre-side-effect value.
  - Go to RESP.
- RESP:
  - rvalid_o = 1, err_o = err; rdata_o is valid only for reads.
  - gnt_o = 0.
  - Return to IDLE.
- Out-of-range read returns rdata_o = 0 with err_o = 1.
- gnt_o = 0 in ACCESS and RESP, so there are no back-to-back accepts. Throughput is one access per 3 cycles.
- Hardware arbitration runs every cycle, independent of the FSM:
  - Eligible requesters: hw_req_i[i] = 1 and hw_idx_i[i] < NF.
  - Also ineligible: while ACCESS is performing an in-range write, any requester whose hw_idx_i[i] equals the software target.
  - Round-robin from pointer ptr: the first eligible index at or after ptr, wrapping, wins.
  - Winner w: hw_gnt_o[w] = 1, field_de_o[hw_idx_i[w]] = 1, field_d_o = hw_data_i[w]. After the grant, ptr ← (w+1) mod NH.
  - No eligible requester: all grants and enables are 0; ptr holds.
  - A requester with an out-of-range index is never granted; it must drop its request itself.
- A software read and a hardware update to the same field may strobe in the same cycle. The captured rdata is the pre-update value.

## Timing
- Reset values:
  - FSM = IDLE, ptr = 0.
  - rvalid_o, err_o = 0; rdata_o = 0.
  - sw_we_o, sw_re_o = 0; sw_wd_o = 0.
  - Captured request registers = 0.
- Software latency: accept at cycle T, strobe at T+1, rvalid_o at T+2.
- sw_we_o, sw_re_o and sw_wd_o are combinational from the FSM state and registers; they are high for exactly one cycle per accepted access.
- Hardware grant is same-cycle combinational; field_de_o is also combinational. The field commits the update on the next clock edge.
- A requester holds hw_req_i, hw_idx_i and hw_data_i stable until it sees hw_gnt_o.
- Reset asserted mid-access: the FSM returns to IDLE immediately and no response is produced.

## Test plan
- Write then read: write addr=2, wdata=0xDEADBEEF, be=0xF. Required: sw_we_o = 0x04 at T+1 and rvalid_o at T+2. A following read returns 0xDEADBEEF with err_o = 0.
- Byte-enable merge: field 1 qs = 0x11223344; write wdata = 0xAABBCCDD, be = 0x5. Required: sw_wd_o = 0x11BB33DD.
- Out-of-range access: read addr = 9 with NF = 8. Required: no sw_re_o, rvalid_o with err_o = 1 and rdata_o = 0.
- Round-robin: hw_req_i = 0b111 held continuously, all indices distinct. Required: grants 0b001, 0b010, 0b100, 0b001 on successive cycles.
- SW/HW conflict: software write to field 3 while requesters 0 and 1 both target field 3, ptr = 0. Required: during ACCESS, hw_gnt_o = 0 and field_de_o[3] = 0. The next cycle grants requester 0.
- Read-to-clear race: read field 5 while requester 2 updates field 5 with 0x7 in the same cycle. Required: rdata_o = old value, with sw_re_o[5] and field_de_o[5] both pulsed.

Source files
------------

// File: rtl/iommu_reg_access_ctrl.sv
// iommu_reg_access_ctrl
// Sequences software register accesses and hardware field updates for a bank
// of NF 32-bit IOMMU register fields (field k lives at word address k).
//
// Software path: one access at a time, IDLE -> ACCESS -> RESP.
//   req_i/gnt_o/we_i/addr_i/wdata_i/be_i : request/grant bus in
//   rvalid_o/rdata_o/err_o               : registered one-cycle response
//   sw_we_o/sw_re_o/sw_wd_o              : one-hot write/read strobes and merged
//                                          write data, driven during ACCESS
//   field_qs_i                           : current field values, field k at [k*DW +: DW]
// Hardware path: round-robin arbitration among NH requesters every cycle.
//   hw_req_i/hw_idx_i/hw_data_i          : per-requester request, target, data
//   hw_gnt_o                             : one-hot grant (combinational)
//   field_de_o/field_d_o                 : one-hot update enable and data
module iommu_reg_access_ctrl #(
    parameter int NF = 8,
    parameter int DW = 32,
    parameter int NH = 3,
    parameter int AW = 8,
    parameter int IW = $clog2(NF)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_i,
    output logic               gnt_o,
    input  logic               we_i,
    input  logic [AW-1:0]      addr_i,
    input  logic [DW-1:0]      wdata_i,
    input  logic [DW/8-1:0]    be_i,
    output logic               rvalid_o,
    output logic [DW-1:0]      rdata_o,
    output logic               err_o,
    output logic [NF-1:0]      sw_we_o,
    output logic [NF-1:0]      sw_re_o,
    output logic [DW-1:0]      sw_wd_o,
    input  logic [NF*DW-1:0]   field_qs_i,
    input  logic [NH-1:0]      hw_req_i,
    input  logic [NH*IW-1:0]   hw_idx_i,
    input  logic [NH*DW-1:0]   hw_data_i,
    output logic [NH-1:0]      hw_gnt_o,
    output logic [NF-1:0]      field_de_o,
    output logic [DW-1:0]      field_d_o
);

    localparam int BW = DW / 8;
    localparam int PW = (NH > 1) ? $clog2(NH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e            state_r;
    logic              we_r;
    logic [AW-1:0]     addr_r;
    logic [DW-1:0]     wdata_r;
    logic [BW-1:0]     be_r;
    logic              rvalid_r;
    logic              err_r;
    logic [DW-1:0]     rdata_r;
    logic [PW-1:0]     ptr_r;

    logic              in_range_s;
    logic [IW-1:0]     sw_idx_s;
    logic [DW-1:0]     qs_s;
    logic [DW-1:0]     mask_s;
    logic              sw_wr_act_s;
    logic [NH-1:0]     elig_s;
    logic              found_s;
    logic [PW-1:0]     win_s;

    // Expand each byte enable into a full byte of write mask.
    function automatic logic [DW-1:0] be_to_mask(input logic [BW-1:0] be);
        logic [DW-1:0] m;
        m = {DW{1'b0}};
        for (int b = 0; b < BW; b++) begin
            m[b*8 +: 8] = {8{be[b]}};
        end
        return m;
    endfunction

    assign gnt_o    = req_i & (state_r == IDLE);
    assign rvalid_o = rvalid_r;
    assign err_o    = err_r;
    assign rdata_o  = rdata_r;

    // Decode the captured address and select the addressed field value.
    always_comb begin
        in_range_s  = (32'(addr_r) < 32'(NF));
        sw_idx_s    = addr_r[IW-1:0];
        qs_s        = field_qs_i[sw_idx_s*DW +: DW];
        mask_s      = be_to_mask(be_r);
        sw_wr_act_s = (state_r == ACCESS) && we_r && in_range_s;
    end

    // Software strobes: exactly one cycle, only in ACCESS and only in range.
    always_comb begin
        sw_we_o = {NF{1'b0}};
        sw_re_o = {NF{1'b0}};
        sw_wd_o = {DW{1'b0}};
        if ((state_r == ACCESS) && in_range_s) begin
            if (we_r) begin
                sw_we_o[sw_idx_s] = 1'b1;
                sw_wd_o           = (qs_s & ~mask_s) | (wdata_r & mask_s);
            end else begin
                sw_re_o[sw_idx_s] = 1'b1;
            end
        end else begin
            sw_wd_o = {DW{1'b0}};
        end
    end

    // Round-robin hardware arbitration; a requester targeting the field being
    // written by software this cycle is held off so the two never collide.
    always_comb begin
        for (int i = 0; i < NH; i++) begin
            elig_s[i] = hw_req_i[i]
                      && (32'(hw_idx_i[i*IW +: IW]) < 32'(NF))
                      && !(sw_wr_act_s && (hw_idx_i[i*IW +: IW] == sw_idx_s));
        end
        found_s = 1'b0;
        win_s   = {PW{1'b0}};
        for (int off = 0; off < NH; off++) begin
            if (!found_s && elig_s[(int'(ptr_r) + off) % NH]) begin
                found_s = 1'b1;
                win_s   = PW'((int'(ptr_r) + off) % NH);
            end else begin
                found_s = found_s;
            end
        end
        hw_gnt_o   = {NH{1'b0}};
        field_de_o = {NF{1'b0}};
        field_d_o  = {DW{1'b0}};
        if (found_s) begin
            hw_gnt_o[win_s]                         = 1'b1;
            field_de_o[hw_idx_i[win_s*IW +: IW]]    = 1'b1;
            field_d_o                               = hw_data_i[win_s*DW +: DW];
        end else begin
            field_d_o = {DW{1'b0}};
        end
    end

    // Round-robin pointer advances past the winner, holds when nobody wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_r <= {PW{1'b0}};
        end else if (found_s) begin
            ptr_r <= (int'(win_s) == NH - 1) ? {PW{1'b0}} : win_s + PW'(32'd1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Software access FSM with registered response outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r  <= IDLE;
            we_r     <= 1'b0;
            addr_r   <= {AW{1'b0}};
            wdata_r  <= {DW{1'b0}};
            be_r     <= {BW{1'b0}};
            rvalid_r <= 1'b0;
            err_r    <= 1'b0;
            rdata_r  <= {DW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    rvalid_r <= 1'b0;
                    err_r    <= 1'b0;
                    if (req_i) begin
                        we_r    <= we_i;
                        addr_r  <= addr_i;
                        wdata_r <= wdata_i;
                        be_r    <= be_i;
                        state_r <= ACCESS;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    // Capture happens on the same edge a read-to-clear or a
                    // hardware update commits, so rdata is the old value.
                    rvalid_r <= 1'b1;
                    err_r    <= !in_range_s;
                    rdata_r  <= (!we_r && in_range_s) ? qs_s : {DW{1'b0}};
                    state_r  <= RESP;
                end
                RESP: begin
                    rvalid_r <= 1'b0;
                    err_r    <= 1'b0;
                    state_r  <= IDLE;
                end
                default: begin
                    rvalid_r <= 1'b0;
                    err_r    <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iommu_reg_access_ctrl.sv
module tb_iommu_reg_access_ctrl;
    localparam int NF = 8;
    localparam int DW = 32;
    localparam int NH = 3;
    localparam int AW = 8;
    localparam int IW = 3;

    typedef struct packed {
        logic          err;
        logic [DW-1:0] rdata;
    } resp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req, gnt, we;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     wdata;
    logic [DW/8-1:0]   be;
    logic              rvalid, err;
    logic [DW-1:0]     rdata;
    logic [NF-1:0]     sw_we, sw_re;
    logic [DW-1:0]     sw_wd;
    logic [NF*DW-1:0]  field_qs;
    logic [NH-1:0]     hw_req;
    logic [NH*IW-1:0]  hw_idx;
    logic [NH*DW-1:0]  hw_data;
    logic [NH-1:0]     hw_gnt;
    logic [NF-1:0]     field_de;
    logic [DW-1:0]     field_d;

    logic [DW-1:0]     mem [NF];
    resp_t             sb_q[$];
    resp_t             mon_e;
    int                n_checks = 0;
    int                n_pass   = 0;
    int                n_resp   = 0;

    always #5 clk = ~clk;

    iommu_reg_access_ctrl #(.NF(NF), .DW(DW), .NH(NH), .AW(AW), .IW(IW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_i(req), .gnt_o(gnt), .we_i(we), .addr_i(addr), .wdata_i(wdata), .be_i(be),
        .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
        .sw_we_o(sw_we), .sw_re_o(sw_re), .sw_wd_o(sw_wd), .field_qs_i(field_qs),
        .hw_req_i(hw_req), .hw_idx_i(hw_idx), .hw_data_i(hw_data),
        .hw_gnt_o(hw_gnt), .field_de_o(field_de), .field_d_o(field_d)
    );

    function automatic logic [31:0] init_val(input int k);
        return (k == 1) ? 32'h1122_3344 : (32'hC0DE_0000 + 32'(k));
    endfunction

    // Simple field bank standing in for the register field instances.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NF; k++) mem[k] <= init_val(k);
        end else begin
            for (int k = 0; k < NF; k++) begin
                if (sw_we[k]) mem[k] <= sw_wd;
                else if (field_de[k]) mem[k] <= field_d;
            end
        end
    end

    always_comb begin
        field_qs = {NF*DW{1'b0}};
        for (int k = 0; k < NF; k++) field_qs[k*DW +: DW] = mem[k];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Response monitor: every rvalid pulse pops one expected response.
    always @(negedge clk) begin
        if (rst_n && rvalid) begin
            n_resp++;
            if (sb_q.size() == 0) begin
                chk("unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("rdata", rdata, mon_e.rdata);
                chk("err", {31'd0, err}, {31'd0, mon_e.err});
            end
        end
    end

    // Drive a request in IDLE and return positioned in the ACCESS cycle.
    task automatic sw_start(input logic w, input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] b, input logic [31:0] exp_wd,
                            input logic [31:0] exp_rd, input logic exp_resp);
        logic [7:0] sel;
        resp_t      e;
        sel = (a < 8'd8) ? (8'd1 << a[2:0]) : 8'd0;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        #1 chk("gnt_idle", {31'd0, gnt}, 32'd1);
        e.err   = (a >= 8'd8);
        e.rdata = (!w && (a < 8'd8)) ? exp_rd : 32'd0;
        if (exp_resp) sb_q.push_back(e);
        @(negedge clk);
        #1 chk("gnt_access", {31'd0, gnt}, 32'd0);
        req = 1'b0;
        chk("sw_we", {24'd0, sw_we}, w ? {24'd0, sel} : 32'd0);
        chk("sw_re", {24'd0, sw_re}, w ? 32'd0 : {24'd0, sel});
        if (w && (a < 8'd8)) chk("sw_wd", sw_wd, exp_wd);
    endtask

    // Move into the RESP cycle; the monitor checks the response itself.
    task automatic sw_finish();
        @(negedge clk);
        req = 1'b1;
        #1 chk("gnt_resp", {31'd0, gnt}, 32'd0);
        req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [2:0] rr_exp [4];
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = 8'd0; wdata = 32'd0; be = 4'd0;
        hw_req = 3'b000; hw_idx = 9'd0; hw_data = {NH*DW{1'b0}};
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_sw_we", {24'd0, sw_we}, 32'd0);
        chk("rst_sw_re", {24'd0, sw_re}, 32'd0);
        chk("rst_sw_wd", sw_wd, 32'd0);
        rst_n = 1'b1;

        // SW/HW conflict on field 3 with ptr = 0.
        hw_idx  = {3'd0, 3'd3, 3'd3};
        hw_data = {32'h0, 32'h0000_5678, 32'h0000_1234};
        sw_start(1'b1, 8'd3, 32'hCAFE_F00D, 4'hF, 32'hCAFE_F00D, 32'd0, 1'b1);
        hw_req = 3'b011;
        #1 chk("conf_gnt_access", {29'd0, hw_gnt}, 32'd0);
        chk("conf_de_access", {24'd0, field_de}, 32'd0);
        sw_finish();
        chk("conf_gnt_next", {29'd0, hw_gnt}, 32'b001);
        chk("conf_de_next", {24'd0, field_de}, 32'h08);
        chk("conf_d_next", field_d, 32'h0000_1234);
        @(posedge clk); #1 hw_req = 3'b010;
        @(negedge clk); #1 chk("conf_gnt_r1", {29'd0, hw_gnt}, 32'b010);
        chk("conf_d_r1", field_d, 32'h0000_5678);
        @(posedge clk); #1 hw_req = 3'b000;
        sw_start(1'b0, 8'd3, 32'd0, 4'h0, 32'd0, 32'h0000_5678, 1'b1);
        sw_finish();

        // Write then read field 2.
        sw_start(1'b1, 8'd2, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF, 32'd0, 1'b1);
        sw_finish();
        sw_start(1'b0, 8'd2, 32'd0, 4'h0, 32'd0, 32'hDEAD_BEEF, 1'b1);
        sw_finish();

        // Byte-enable merge into field 1, then zero byte enables on field 4.
        sw_start(1'b1, 8'd1, 32'hAABB_CCDD, 4'h5, 32'h11BB_33DD, 32'd0, 1'b1);
        sw_finish();
        sw_start(1'b0, 8'd1, 32'd0, 4'h0, 32'd0, 32'h11BB_33DD, 1'b1);
        sw_finish();
        sw_start(1'b1, 8'd4, 32'hFFFF_FFFF, 4'h0, 32'hC0DE_0004, 32'd0, 1'b1);
        sw_finish();

        // Out-of-range read and write.
        sw_start(1'b0, 8'd9, 32'd0, 4'h0, 32'd0, 32'd0, 1'b1);
        sw_finish();
        sw_start(1'b1, 8'd200, 32'h1234_5678, 4'hF, 32'd0, 32'd0, 1'b1);
        sw_finish();

        // Read-to-clear race on field 5 with requester 2.
        hw_idx  = {3'd5, 3'd1, 3'd0};
        hw_data = {32'h0000_0007, 32'h0, 32'h0};
        sw_start(1'b0, 8'd5, 32'd0, 4'h0, 32'd0, 32'hC0DE_0005, 1'b1);
        hw_req = 3'b100;
        #1 chk("race_de", {24'd0, field_de}, 32'h20);
        chk("race_gnt", {29'd0, hw_gnt}, 32'b100);
        @(posedge clk); #1 hw_req = 3'b000;
        sw_finish();
        sw_start(1'b0, 8'd5, 32'd0, 4'h0, 32'd0, 32'h0000_0007, 1'b1);
        sw_finish();

        // Round-robin with all three requesting distinct fields, from ptr = 0.
        do_reset();
        hw_idx  = {3'd2, 3'd1, 3'd0};
        hw_data = {32'hC, 32'hB, 32'hA};
        @(posedge clk); #1 hw_req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1 chk("rr_gnt", {29'd0, hw_gnt}, {29'd0, rr_exp[i]});
        end
        @(posedge clk); #1 hw_req = 3'b000;

        // Reset during ACCESS: no strobes afterwards and no response.
        sw_start(1'b0, 8'd2, 32'd0, 4'h0, 32'd0, 32'd0, 1'b0);
        rst_n = 1'b0;
        #1 chk("rst_mid_re", {24'd0, sw_re}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk("rst_mid_rvalid", {31'd0, rvalid}, 32'd0);
        end

        chk("resp_count", 32'(n_resp), 32'd11);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

endmodule
